// File: rtl/adder_selftest_sequencer.sv
// adder_selftest_sequencer
// Self-test sequencer for a combinational N-bit adder under test. It drives
// operands A/B and compares the adder's sum, carry-out and signed overflow
// against an internal A+B golden model. Eight directed corner vectors run
// first, followed by pseudo-random vectors from a Galois LFSR. The sequencer
// counts mismatching vectors and captures the first failing vector.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - begin a run (honoured only when idle or done)
//   A, B            - registered operands to the adder under test
//   dut_sum/cout/overflow - adder results, sampled in the CHECK cycle
//   busy, done, pass       - run status (done/pass are levels held in DONE)
//   vec_idx                - index of the vector currently driven
//   err_count              - mismatching vectors, saturating at 16'hFFFF
//   first_fail_idx/_a/_b   - first mismatch (idx 16'hFFFF when none)
module adder_selftest_sequencer #(
    parameter int          N           = 32,
    parameter int          NUM_VECTORS = 256,
    parameter int          SETTLE      = 1,
    parameter logic [31:0] SEED        = 32'hACE11234
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [N-1:0]  A,
    output logic [N-1:0]  B,
    input  logic [N-1:0]  dut_sum,
    input  logic          dut_cout,
    input  logic          dut_overflow,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   vec_idx,
    output logic [15:0]   err_count,
    output logic [15:0]   first_fail_idx,
    output logic [N-1:0]  first_fail_a,
    output logic [N-1:0]  first_fail_b
);

    // Loading of a vector happens on the accepting edge and on each CHECK
    // edge, so no separate LOAD state cycle exists.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0] ZERO_V = {N{1'b0}};
    localparam logic [N-1:0] ONE_V  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ONES_V = {N{1'b1}};
    localparam logic [N-1:0] MAX_V  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_V  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] P20_V  = N'(32'd20);
    localparam logic [N-1:0] P30_V  = N'(32'd30);
    localparam logic [N-1:0] N20_V  = ZERO_V - P20_V;
    localparam logic [N-1:0] N30_V  = ZERO_V - P30_V;
    localparam logic [15:0]  LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0]  NO_FAIL     = 16'hFFFF;
    localparam bit           HAS_SETTLE  = (SETTLE > 0);
    localparam logic [3:0]   SETTLE_INIT = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

    // Galois LFSR, one step to the right.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        if (x[0]) begin
            lfsr_step = {1'b0, x[31:1]} ^ 32'h80200003;
        end else begin
            lfsr_step = {1'b0, x[31:1]};
        end
    endfunction

    // Directed corner vectors, operand A.
    function automatic logic [N-1:0] dir_a(input logic [2:0] k);
        case (k)
            3'd0:    dir_a = P20_V;
            3'd1:    dir_a = N20_V;
            3'd2:    dir_a = P20_V;
            3'd3:    dir_a = MAX_V;
            3'd4:    dir_a = MIN_V;
            3'd5:    dir_a = ONES_V;
            3'd6:    dir_a = ZERO_V;
            3'd7:    dir_a = MAX_V;
            default: dir_a = ZERO_V;
        endcase
    endfunction

    // Directed corner vectors, operand B.
    function automatic logic [N-1:0] dir_b(input logic [2:0] k);
        case (k)
            3'd0:    dir_b = P30_V;
            3'd1:    dir_b = N30_V;
            3'd2:    dir_b = N30_V;
            3'd3:    dir_b = ONE_V;
            3'd4:    dir_b = ONES_V;
            3'd5:    dir_b = ONE_V;
            3'd6:    dir_b = ZERO_V;
            3'd7:    dir_b = MIN_V;
            default: dir_b = ZERO_V;
        endcase
    endfunction

    state_t        state_r;
    logic [3:0]    settle_cnt_r;
    logic [31:0]   lfsr_r;

    logic [15:0]   next_idx_s;
    logic [N-1:0]  next_a_s;
    logic [N-1:0]  next_b_s;
    logic [31:0]   next_lfsr_s;
    logic [31:0]   lfsr_s1;
    logic [31:0]   lfsr_s2;
    logic [N:0]    g_full_s;
    logic          g_ovf_s;
    logic          mismatch_s;
    logic [15:0]   err_next_s;
    logic          is_last_s;

    // Next vector to load: index 0 on accept, vec_idx+1 from CHECK.
    always_comb begin
        lfsr_s1 = lfsr_step(lfsr_r);
        lfsr_s2 = lfsr_step(lfsr_s1);
        if (state_r == ST_CHECK) begin
            next_idx_s = vec_idx + 16'd1;
        end else begin
            next_idx_s = 16'd0;
        end
        // The LFSR only advances for random vectors (index 8 onward).
        if (next_idx_s < 16'd8) begin
            next_a_s    = dir_a(next_idx_s[2:0]);
            next_b_s    = dir_b(next_idx_s[2:0]);
            next_lfsr_s = lfsr_r;
        end else begin
            next_a_s    = lfsr_s1[N-1:0];
            next_b_s    = lfsr_s2[N-1:0];
            next_lfsr_s = lfsr_s2;
        end
    end

    // Golden model of the current vector and mismatch bookkeeping.
    always_comb begin
        g_full_s   = {1'b0, A} + {1'b0, B};
        g_ovf_s    = (A[N-1] == B[N-1]) && (g_full_s[N-1] != A[N-1]);
        mismatch_s = (dut_sum != g_full_s[N-1:0]) || (dut_cout != g_full_s[N])
                     || (dut_overflow != g_ovf_s);
        if (mismatch_s && (err_count != 16'hFFFF)) begin
            err_next_s = err_count + 16'd1;
        end else begin
            err_next_s = err_count;
        end
        is_last_s = (vec_idx == LAST_IDX);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            settle_cnt_r   <= 4'd0;
            lfsr_r         <= SEED;
            A              <= ZERO_V;
            B              <= ZERO_V;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_idx        <= 16'd0;
            err_count      <= 16'd0;
            first_fail_idx <= NO_FAIL;
            first_fail_a   <= ZERO_V;
            first_fail_b   <= ZERO_V;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Accept: clear results and drive vector 0 on this edge.
                        state_r        <= HAS_SETTLE ? ST_SETTLE : ST_CHECK;
                        settle_cnt_r   <= SETTLE_INIT;
                        lfsr_r         <= SEED;
                        A              <= next_a_s;
                        B              <= next_b_s;
                        vec_idx        <= 16'd0;
                        err_count      <= 16'd0;
                        first_fail_idx <= NO_FAIL;
                        first_fail_a   <= ZERO_V;
                        first_fail_b   <= ZERO_V;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == 4'd0) begin
                        state_r <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next_s;
                    if (mismatch_s && (first_fail_idx == NO_FAIL)) begin
                        first_fail_idx <= vec_idx;
                        first_fail_a   <= A;
                        first_fail_b   <= B;
                    end
                    if (is_last_s) begin
                        // A/B and vec_idx keep the final vector.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == 16'd0);
                    end else begin
                        state_r      <= HAS_SETTLE ? ST_SETTLE : ST_CHECK;
                        settle_cnt_r <= SETTLE_INIT;
                        lfsr_r       <= next_lfsr_s;
                        A            <= next_a_s;
                        B            <= next_b_s;
                        vec_idx      <= next_idx_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
